sram_1r1w_clr: RTL



---
 rtl/sram_1r1w_clr_if.sv | 27 ++
 rtl/sram_1r1w_clr.sv | 110 +++++++++++
 2 files changed

// File: rtl/sram_1r1w_clr_if.sv
// User-side bus of the 1R1W clearable SRAM: read port, write port with bit
// mask, clear request and busy/valid status.
interface sram_1r1w_clr_if #(
  parameter int BITS       = 15,
  parameter int ADDR_WIDTH = 12
);
  logic                  clr_req_in;
  logic                  clr_busy_out;
  logic                  rd_ce_in;
  logic [ADDR_WIDTH-1:0] rd_addr_in;
  logic [BITS-1:0]       rd_out;
  logic                  rd_valid_out;
  logic                  wr_ce_in;
  logic [ADDR_WIDTH-1:0] wr_addr_in;
  logic [BITS-1:0]       wd_in;
  logic [BITS-1:0]       w_mask_in;

  modport slave (
    input  clr_req_in, rd_ce_in, rd_addr_in, wr_ce_in, wr_addr_in, wd_in, w_mask_in,
    output clr_busy_out, rd_out, rd_valid_out
  );

  modport master (
    output clr_req_in, rd_ce_in, rd_addr_in, wr_ce_in, wr_addr_in, wd_in, w_mask_in,
    input  clr_busy_out, rd_out, rd_valid_out
  );
endinterface

// File: rtl/sram_1r1w_clr.sv
// Behavioural 1R1W SRAM with per-bit write mask, read-valid strobe and a clear
// engine that fills the array with INIT_VALUE. SRAM_OUTREG_EN adds an output register.
module sram_1r1w_clr #(
  parameter int              BITS           = 15,
  parameter int              WORD_DEPTH     = 4096,
  parameter int              ADDR_WIDTH     = 12,
  parameter logic [BITS-1:0] INIT_VALUE     = '0,
  parameter bit              CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_1r1w_clr_if.slave       bus
);

`ifdef SRAM_OUTREG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  localparam int                    IW      = $clog2(WORD_DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(WORD_DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_e;
  localparam state_e RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [BITS-1:0]       mem [WORD_DEPTH];
  logic [BITS-1:0]       rd_q;
  logic [STAGES-1:0]     vld_pipe;

  logic clearing, rd_go, wr_go, rd_in_rng, wr_in_rng, wr_poison;

  assign clearing  = (state_q == CLEAR);
  assign rd_in_rng = {1'b0, bus.rd_addr_in} < DEPTH_W;
  assign wr_in_rng = {1'b0, bus.wr_addr_in} < DEPTH_W;
  assign rd_go     = !clearing && bus.rd_ce_in;
  assign wr_go     = !clearing && bus.wr_ce_in && wr_in_rng;
  assign bus.clr_busy_out = clearing;

`ifndef SYNTHESIS
  // An unknown write address or mask could hit any word, so poison them all.
  assign wr_poison = !clearing && bus.wr_ce_in &&
                     ($isunknown(bus.wr_addr_in) || $isunknown(bus.w_mask_in));
`else
  assign wr_poison = 1'b0;
`endif

  // Clear FSM: counter parks on the last address once the sweep completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.clr_req_in) begin
          state_q <= CLEAR;
          cnt_q   <= '0;
        end
        CLEAR: begin
          if (cnt_q == LAST_A) state_q <= IDLE;
          else                 cnt_q   <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (clearing)
      mem[cnt_q[IW-1:0]] <= INIT_VALUE;
    else if (wr_poison)
      mem <= '{default: 'x};
    else if (wr_go)
      mem[bus.wr_addr_in[IW-1:0]] <= (bus.wd_in & bus.w_mask_in) |
                                     (mem[bus.wr_addr_in[IW-1:0]] & ~bus.w_mask_in);
  end

  // Read-first: the NBA write above lands after this sample on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      vld_pipe <= '0;
    end else begin
      if (rd_go) rd_q <= rd_in_rng ? mem[bus.rd_addr_in[IW-1:0]] : '0;
      vld_pipe[0] <= rd_go;
      for (int i = 1; i < STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

`ifdef SRAM_OUTREG_EN
  logic [BITS-1:0] rd2_q;

  // Advances regardless of FSM state so a read accepted just before a clear drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           rd2_q <= '0;
    else if (vld_pipe[0]) rd2_q <= rd_q;
  end

  assign bus.rd_out = rd2_q;
`else
  assign bus.rd_out = rd_q;
`endif

  assign bus.rd_valid_out = vld_pipe[STAGES-1];

endmodule
